// File: rtl/edge_event_arbiter_if.sv
// Event port between edge_event_arbiter (master) and its consumer (slave).
// evt_level exists only when EDGE_ARB_BOTH_EDGES_EN is defined.
// Handshake: the master holds evt_valid and the payload stable until it samples
// evt_valid & evt_ready at a posedge; the consumer may drive evt_ready freely.
interface edge_event_arbiter_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 8
);
  localparam int ID_W = $clog2(N_CH);

  logic             evt_valid;
  logic             evt_ready;
  logic [ID_W-1:0]  evt_id;
  logic [CNT_W-1:0] evt_count;
  logic             evt_sat;
`ifdef EDGE_ARB_BOTH_EDGES_EN
  logic             evt_level;
`endif

  modport master (
    output evt_valid, evt_id, evt_count, evt_sat,
`ifdef EDGE_ARB_BOTH_EDGES_EN
    output evt_level,
`endif
    input  evt_ready
  );

  modport slave (
    input  evt_valid, evt_id, evt_count, evt_sat,
`ifdef EDGE_ARB_BOTH_EDGES_EN
    input  evt_level,
`endif
    output evt_ready
  );
endinterface

// File: rtl/edge_event_arbiter.sv
// Coalesces per-channel edges into saturating counts and serves them round-robin
// over one registered valid/ready slot. EDGE_ARB_BOTH_EDGES_EN counts both edges and adds evt_level.
module edge_event_arbiter #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 8,
  localparam int ID_W = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] sig,
  input  logic [N_CH-1:0] ch_en,
  edge_event_arbiter_if.master evt
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             armed;
  logic [N_CH-1:0]  prev_sig;
  logic [N_CH-1:0]  pending;
  logic [N_CH-1:0]  sat;
  logic [CNT_W-1:0] cnt [N_CH];
  logic [ID_W-1:0]  rr;

  logic [N_CH-1:0]  edge_det;
  logic [N_CH-1:0]  hit;
  logic [N_CH-1:0]  req;
  logic [ID_W-1:0]  winner;
  logic             found;
  logic             slot_free;
  logic             load;
  int               idx;

`ifdef EDGE_ARB_BOTH_EDGES_EN
  assign edge_det = sig ^ prev_sig;
`else
  assign edge_det = sig & ~prev_sig;
`endif

  // prev_sig is zero straight out of reset, so the first cycle after release only
  // samples sig; otherwise a channel held high through reset would look like an edge.
  assign hit       = armed ? (edge_det & ch_en) : '0;
  assign req       = pending & ch_en;
  assign slot_free = !evt.evt_valid || evt.evt_ready;
  assign load      = slot_free && found;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 0; k < N_CH; k++) begin
      idx = int'(rr) + k;
      if (idx >= N_CH) idx = idx - N_CH;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed         <= 1'b0;
      prev_sig      <= '0;
      pending       <= '0;
      sat           <= '0;
      for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
      rr            <= '0;
      evt.evt_valid <= 1'b0;
      evt.evt_id    <= '0;
      evt.evt_count <= '0;
      evt.evt_sat   <= 1'b0;
    end else begin
      armed    <= 1'b1;
      prev_sig <= sig;

      for (int i = 0; i < N_CH; i++) begin
        if (!ch_en[i]) begin
          pending[i] <= 1'b0;
          cnt[i]     <= '0;
          sat[i]     <= 1'b0;
        end else if (load && winner == ID_W'(i)) begin
          // The old count moves to the slot; an edge arriving now starts a fresh count.
          pending[i] <= hit[i];
          cnt[i]     <= hit[i] ? CNT_W'(1) : '0;
          sat[i]     <= 1'b0;
        end else if (hit[i]) begin
          pending[i] <= 1'b1;
          if (cnt[i] == CNT_MAX) sat[i] <= 1'b1;
          else                   cnt[i] <= cnt[i] + 1'b1;
        end
      end

      if (slot_free) begin
        if (found) begin
          evt.evt_valid <= 1'b1;
          evt.evt_id    <= winner;
          evt.evt_count <= cnt[winner];
          evt.evt_sat   <= sat[winner];
          rr            <= (winner == ID_W'(N_CH - 1)) ? '0 : winner + 1'b1;
        end else begin
          evt.evt_valid <= 1'b0;
        end
      end
    end
  end

`ifdef EDGE_ARB_BOTH_EDGES_EN
  logic [N_CH-1:0] level;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level         <= '0;
      evt.evt_level <= 1'b0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (hit[i]) level[i] <= sig[i];
      end
      if (load) evt.evt_level <= level[winner];
    end
  end
`endif

endmodule
